// File: rtl/chain_score_pipe_pkg.sv
// chain_pkg: shared constants and types for the chaining transition-score pipe.
//
// Contents:
//   BETA_DIV        divisor applied to dd*avg_qspan when forming beta
//   LAT             input-to-output latency of chain_score_pipe (cycles)
//   DEF_*           default widths and legality limits
//   stage_payload_t per-pair payload layout at the default widths
//                   (valid, ok, dd, alpha, f_j, prod, lg)
package chain_pkg;

    localparam int BETA_DIV     = 100;
    localparam int LAT          = 5;

    localparam int DEF_POS_W    = 32;
    localparam int DEF_SCORE_W  = 32;
    localparam int DEF_SPAN_W   = 16;
    localparam int DEF_MAX_DIST = 5000;
    localparam int DEF_MAX_GAP  = 5000;
    localparam int DEF_LG_W     = $clog2(DEF_POS_W);

    typedef struct packed {
        logic                                 valid;
        logic                                 ok;
        logic [DEF_POS_W-1:0]                 dd;
        logic [DEF_POS_W-1:0]                 alpha;
        logic signed [DEF_SCORE_W-1:0]        f_j;
        logic [DEF_POS_W+DEF_SPAN_W-1:0]      prod;
        logic [DEF_LG_W-1:0]                  lg;
    } stage_payload_t;

endpackage

// File: rtl/chain_score_pipe_if.sv
// chain_score_pipe_if: handshake bundle between the anchor-pair generator
// (master) and the score pipe (slave), including the result side.
//
// Signals:
//   in_valid/in_ready          input pair handshake
//   ri, rj, qi, qj, w          coordinates and seed width (unsigned, POS_W)
//   avg_qspan                  average query span (unsigned, SPAN_W)
//   f_j                        predecessor chain score (signed, SCORE_W)
//   out_valid/out_ready        result handshake
//   out_score, out_ok          signed transition score and pair legality
interface chain_score_pipe_if #(
    parameter int POS_W   = 32,
    parameter int SCORE_W = 32,
    parameter int SPAN_W  = 16
);

    logic                      in_valid;
    logic                      in_ready;
    logic [POS_W-1:0]          ri;
    logic [POS_W-1:0]          rj;
    logic [POS_W-1:0]          qi;
    logic [POS_W-1:0]          qj;
    logic [POS_W-1:0]          w;
    logic [SPAN_W-1:0]         avg_qspan;
    logic signed [SCORE_W-1:0] f_j;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [SCORE_W-1:0] out_score;
    logic                      out_ok;

    modport master (
        output in_valid, ri, rj, qi, qj, w, avg_qspan, f_j, out_ready,
        input  in_ready, out_valid, out_score, out_ok
    );

    modport slave (
        input  in_valid, ri, rj, qi, qj, w, avg_qspan, f_j, out_ready,
        output in_ready, out_valid, out_score, out_ok
    );

endinterface

// File: rtl/chain_score_pipe_ilog2.sv
// chain_ilog2: combinational floor(log2(val)) as a leading-one priority
// encoder. Returns 0 for val of 0 or 1.
//
// Ports:
//   val  in   POS_W   value to encode
//   lg   out  LG_W    index of the most significant set bit
module chain_ilog2 #(
    parameter int POS_W = 32,
    parameter int LG_W  = $clog2(POS_W)
) (
    input  logic [POS_W-1:0] val,
    output logic [LG_W-1:0]  lg
);

    // Ascending scan: the last set bit seen wins, giving the MSB index.
    always_comb begin
        lg = '0;
        for (int i = 1; i < POS_W; i++) begin
            if (val[i]) begin
                lg = LG_W'(i);
            end
        end
    end

endmodule

// File: rtl/chain_score_pipe.sv
// chain_score_pipe: five-stage back-pressurable pipe computing the chaining
// transition score f[j] + alpha - beta and a legality flag for one
// (anchor i, predecessor j) pair per cycle.
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-high reset; flushes all in-flight pairs
//   bus    chain_score_pipe_if.slave (pair input and result output handshakes)
//
// Configuration macro:
//   CHAIN_SCORE_SAT_EN  defined: final score saturates to the SCORE_W range;
//                       undefined: final score wraps (low SCORE_W bits).
//
// Flow control: a single global stall (result valid but not taken) freezes
// every stage, so bubbles are kept and the output holds steady.
module chain_score_pipe
    import chain_pkg::*;
#(
    parameter int POS_W    = DEF_POS_W,
    parameter int SCORE_W  = DEF_SCORE_W,
    parameter int SPAN_W   = DEF_SPAN_W,
    parameter int MAX_DIST = DEF_MAX_DIST,
    parameter int MAX_GAP  = DEF_MAX_GAP
) (
    input logic              clk,
    input logic              reset,
    chain_score_pipe_if.slave bus
);

    localparam int D_W    = POS_W + 1;            // signed coordinate deltas
    localparam int G_W    = POS_W + 2;            // signed delta difference
    localparam int PROD_W = POS_W + SPAN_W;       // full dd*avg_qspan
    localparam int LG_W   = $clog2(POS_W);
    // Wide enough for f_j plus alpha minus an arbitrary beta without overflow.
    localparam int SUM_W  = (SCORE_W + 2 > PROD_W + 2) ? SCORE_W + 2 : PROD_W + 2;

    localparam logic signed [D_W-1:0] MAX_DIST_S = D_W'(MAX_DIST);
    localparam logic signed [G_W-1:0] MAX_GAP_S  = G_W'(MAX_GAP);

    // Narrow the wide sum to SCORE_W bits.
    function automatic logic signed [SCORE_W-1:0] narrow_score(
        input logic signed [SUM_W-1:0] v
    );
`ifdef CHAIN_SCORE_SAT_EN
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = $signed({{(SUM_W-SCORE_W+1){1'b0}}, {(SCORE_W-1){1'b1}}});
        lo = $signed({{(SUM_W-SCORE_W+1){1'b1}}, {(SCORE_W-1){1'b0}}});
        if (v > hi) begin
            return {1'b0, {(SCORE_W-1){1'b1}}};
        end else if (v < lo) begin
            return {1'b1, {(SCORE_W-1){1'b0}}};
        end else begin
            return v[SCORE_W-1:0];
        end
`else
        return v[SCORE_W-1:0];
`endif
    endfunction

    logic stall;

    logic                      vld_p1, ok_p1;
    logic signed [D_W-1:0]     dr_p1, dq_p1;
    logic [POS_W-1:0]          w_p1;
    logic [SPAN_W-1:0]         span_p1;
    logic signed [SCORE_W-1:0] fj_p1;

    logic                      vld_p2, ok_p2;
    logic [POS_W-1:0]          dd_p2, alpha_p2;
    logic [SPAN_W-1:0]         span_p2;
    logic signed [SCORE_W-1:0] fj_p2;

    logic                      vld_p3, ok_p3;
    logic [POS_W-1:0]          dd_p3, alpha_p3;
    logic [PROD_W-1:0]         prod_p3;
    logic [LG_W-1:0]           lg_p3;
    logic signed [SCORE_W-1:0] fj_p3;

    logic                      vld_p4, ok_p4;
    logic [POS_W-1:0]          alpha_p4;
    logic [PROD_W-1:0]         beta_p4;
    logic signed [SCORE_W-1:0] fj_p4;

    logic                      vld_p5, ok_p5;
    logic signed [SCORE_W-1:0] score_p5;

    assign stall         = vld_p5 && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = vld_p5;
    assign bus.out_score = score_p5;
    assign bus.out_ok    = ok_p5;

    // ---- S1: signed coordinate deltas and distance legality ----
    logic signed [D_W-1:0] dr_c, dq_c;
    logic                  ok1_c;

    assign dr_c  = $signed({1'b0, bus.ri}) - $signed({1'b0, bus.rj});
    assign dq_c  = $signed({1'b0, bus.qi}) - $signed({1'b0, bus.qj});
    // Strictly positive means sign bit clear and not zero.
    assign ok1_c = !dr_c[D_W-1] && (dr_c != '0) && (dr_c <= MAX_DIST_S) &&
                   !dq_c[D_W-1] && (dq_c != '0) && (dq_c <= MAX_DIST_S);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            ok_p1   <= 1'b0;
            dr_p1   <= '0;
            dq_p1   <= '0;
            w_p1    <= '0;
            span_p1 <= '0;
            fj_p1   <= '0;
        end else if (!stall) begin
            vld_p1  <= bus.in_valid;
            ok_p1   <= ok1_c;
            dr_p1   <= dr_c;
            dq_p1   <= dq_c;
            w_p1    <= bus.w;
            span_p1 <= bus.avg_qspan;
            fj_p1   <= bus.f_j;
        end
    end

    // ---- S2: gap, min delta, alpha, gap legality ----
    logic signed [G_W-1:0] diff_c, adiff_c;
    logic signed [D_W-1:0] mn_c;
    logic [POS_W-1:0]      alpha_c;

    assign diff_c  = $signed({dr_p1[D_W-1], dr_p1}) - $signed({dq_p1[D_W-1], dq_p1});
    // |diff| always fits: the extreme difference is below 2^(G_W-1).
    assign adiff_c = diff_c[G_W-1] ? -diff_c : diff_c;
    assign mn_c    = (dr_p1 < dq_p1) ? dr_p1 : dq_p1;
    // On illegal pairs mn may be negative; alpha is then irrelevant.
    assign alpha_c = (mn_c < $signed({1'b0, w_p1})) ? mn_c[POS_W-1:0] : w_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2   <= 1'b0;
            ok_p2    <= 1'b0;
            dd_p2    <= '0;
            alpha_p2 <= '0;
            span_p2  <= '0;
            fj_p2    <= '0;
        end else if (!stall) begin
            vld_p2   <= vld_p1;
            ok_p2    <= ok_p1 && (adiff_c <= MAX_GAP_S);
            dd_p2    <= adiff_c[POS_W-1:0];
            alpha_p2 <= alpha_c;
            span_p2  <= span_p1;
            fj_p2    <= fj_p1;
        end
    end

    // ---- S3: full-width gap product and log2 of the gap ----
    logic [PROD_W-1:0] prod_c;
    logic [LG_W-1:0]   lg_c;

    assign prod_c = {{SPAN_W{1'b0}}, dd_p2} * {{POS_W{1'b0}}, span_p2};

    chain_ilog2 #(
        .POS_W (POS_W),
        .LG_W  (LG_W)
    ) u_ilog2 (
        .val (dd_p2),
        .lg  (lg_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p3   <= 1'b0;
            ok_p3    <= 1'b0;
            dd_p3    <= '0;
            alpha_p3 <= '0;
            prod_p3  <= '0;
            lg_p3    <= '0;
            fj_p3    <= '0;
        end else if (!stall) begin
            vld_p3   <= vld_p2;
            ok_p3    <= ok_p2;
            dd_p3    <= dd_p2;
            alpha_p3 <= alpha_p2;
            prod_p3  <= prod_c;
            lg_p3    <= lg_c;
            fj_p3    <= fj_p2;
        end
    end

    // ---- S4: beta = prod/100 + lg/2, zero for a diagonal pair ----
    logic [PROD_W-1:0] q_c, beta_c;

    assign q_c    = prod_p3 / PROD_W'(BETA_DIV);
    assign beta_c = (dd_p3 == '0) ? '0 : q_c + PROD_W'(lg_p3 >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p4   <= 1'b0;
            ok_p4    <= 1'b0;
            alpha_p4 <= '0;
            beta_p4  <= '0;
            fj_p4    <= '0;
        end else if (!stall) begin
            vld_p4   <= vld_p3;
            ok_p4    <= ok_p3;
            alpha_p4 <= alpha_p3;
            beta_p4  <= beta_c;
            fj_p4    <= fj_p3;
        end
    end

    // ---- S5: signed sum, narrowing, illegal pairs forced to zero ----
    logic signed [SUM_W-1:0]   sum_c;
    logic signed [SCORE_W-1:0] score_c;

    assign sum_c   = SUM_W'(fj_p4) + $signed(SUM_W'(alpha_p4)) - $signed(SUM_W'(beta_p4));
    assign score_c = ok_p4 ? narrow_score(sum_c) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p5   <= 1'b0;
            ok_p5    <= 1'b0;
            score_p5 <= '0;
        end else if (!stall) begin
            vld_p5   <= vld_p4;
            ok_p5    <= ok_p4;
            score_p5 <= score_c;
        end
    end

endmodule
